// File: rtl/loopback_link_emu_pkg.sv
// Shared types and constants for the loopback link emulator.
// Link states, routing modes and timestamp width.
package loopback_link_emu_pkg;

  localparam int TS_W       = 16;
  localparam int MODE_CROSS = 0;
  localparam int MODE_SELF  = 1;

  typedef enum logic [1:0] {
    LINK_DOWN,
    LINK_TRAIN,
    LINK_UP
  } link_state_e;

  // Routing is an involution, so it maps dest->src as well.
  function automatic int route(input int p, input int mode);
    return (mode == MODE_SELF) ? p : (p ^ 1);
  endfunction

endpackage

// File: rtl/loopback_delay_fifo.sv
// Per-destination timestamped FIFO with a programmable release delay.
// The head is released once its age reaches the delay latched while empty.
module loopback_delay_fifo
  import loopback_link_emu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [TS_W-1:0]         now,
  input  logic [15:0]             cfg_delay,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic                    in_last,
  input  logic                    pop,
  output logic                    full,
  output logic                    head_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic                    out_last
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TS_W-1:0]       ts;
    logic                  last;
    logic [KW-1:0]         keep;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [15:0]     dly_q, dly_d;
  logic [TS_W-1:0] age;
  logic            do_push, do_pop;

  always_comb begin
    head       = mem_q[rd_q];
    age        = now - head.ts;
    head_valid = (cnt_q != '0) && (age >= dly_q);
    full       = (cnt_q == (AW+1)'(DEPTH));
    out_data   = head.data;
    out_keep   = head.keep;
    out_last   = head.last;
    do_pop     = pop && head_valid;
    do_push    = push && (!full || do_pop);
    dly_d      = (cnt_q == '0) ? cfg_delay : dly_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      dly_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      dly_q <= dly_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem_q[wr_q] <= '{ts: now, last: in_last, keep: in_keep, data: in_data};
    end
  end

endmodule

// File: rtl/loopback_link_emu.sv
// Multi-port AXI-Stream loopback emulator: routing, link training,
// cycle counter and egress frame counters around per-port delay FIFOs.
module loopback_link_emu
  import loopback_link_emu_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 16,
  parameter int MODE         = 0,
  parameter int TRAIN_CYCLES = 64
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  output logic [NUM_PORTS-1:0]              s_tready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   m_tdata,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_tkeep,
  output logic [NUM_PORTS-1:0]              m_tlast,
  output logic [NUM_PORTS-1:0]              m_tvalid,
  input  logic [NUM_PORTS-1:0]              m_tready,
  input  logic [NUM_PORTS-1:0]              link_en,
  input  logic [NUM_PORTS*16-1:0]           cfg_delay,
  output logic [NUM_PORTS-1:0]              link_up,
  output logic [NUM_PORTS*16-1:0]           frame_cnt
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TRAIN_CYCLES + 1);

  link_state_e          state_q [NUM_PORTS];
  link_state_e          state_d [NUM_PORTS];
  logic [TW-1:0]        train_q [NUM_PORTS];
  logic [TW-1:0]        train_d [NUM_PORTS];
  logic [15:0]          fcnt_q  [NUM_PORTS];
  logic [15:0]          fcnt_d  [NUM_PORTS];
  logic [TS_W-1:0]      now_q, now_d;
  logic [NUM_PORTS-1:0] up, full, hvalid, push, pop, rdy, flush;

  always_comb begin
    now_d = now_q + TS_W'(1);
    for (int d = 0; d < NUM_PORTS; d++) begin
      state_d[d] = state_q[d];
      train_d[d] = train_q[d];
      fcnt_d[d]  = fcnt_q[d];
      if (pop[d] && m_tlast[d] && (fcnt_q[d] != 16'hFFFF)) begin
        fcnt_d[d] = fcnt_q[d] + 16'd1;
      end
      if (!link_en[d]) begin
        state_d[d] = LINK_DOWN;
      end else begin
        unique case (state_q[d])
          LINK_DOWN: begin
            state_d[d] = LINK_TRAIN;
            train_d[d] = '0;
          end
          LINK_TRAIN: begin
            if (train_q[d] == TW'(TRAIN_CYCLES - 1)) state_d[d] = LINK_UP;
            else train_d[d] = train_q[d] + TW'(1);
          end
          LINK_UP: ;
          default: state_d[d] = LINK_DOWN;
        endcase
      end
      flush[d] = (state_d[d] == LINK_DOWN);
      up[d]    = (state_q[d] == LINK_UP);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      now_q <= '0;
      for (int d = 0; d < NUM_PORTS; d++) begin
        state_q[d] <= LINK_DOWN;
        train_q[d] <= '0;
        fcnt_q[d]  <= '0;
      end
    end else begin
      now_q <= now_d;
      for (int d = 0; d < NUM_PORTS; d++) begin
        state_q[d] <= state_d[d];
        train_q[d] <= train_d[d];
        fcnt_q[d]  <= fcnt_d[d];
      end
    end
  end

  for (genvar d = 0; d < NUM_PORTS; d++) begin : g_dst
    localparam int SRC = route(d, MODE);

    logic [DATA_WIDTH-1:0] f_data;
    logic [KW-1:0]         f_keep;
    logic                  f_last;

    // A full FIFO still takes a word when its head leaves the same cycle.
    assign rdy[d]      = up[d] && !RESET && (!full[d] || pop[d]);
    assign push[d]     = s_tvalid[SRC] && rdy[d];
    assign pop[d]      = m_tvalid[d] && m_tready[d];
    assign s_tready[SRC] = rdy[d];
    assign m_tvalid[d] = hvalid[d] && !RESET;
    assign link_up[d]  = up[d] && !RESET;

    assign m_tdata[d*DATA_WIDTH +: DATA_WIDTH] = m_tvalid[d] ? f_data : '0;
    assign m_tkeep[d*KW +: KW]                 = m_tvalid[d] ? f_keep : '0;
    assign m_tlast[d]                          = m_tvalid[d] && f_last;
    assign frame_cnt[d*16 +: 16]               = fcnt_q[d];

    loopback_delay_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk        (CLK),
      .rst        (RESET),
      .flush      (flush[d]),
      .now        (now_q),
      .cfg_delay  (cfg_delay[d*16 +: 16]),
      .push       (push[d]),
      .in_data    (s_tdata[SRC*DATA_WIDTH +: DATA_WIDTH]),
      .in_keep    (s_tkeep[SRC*KW +: KW]),
      .in_last    (s_tlast[SRC]),
      .pop        (pop[d]),
      .full       (full[d]),
      .head_valid (hvalid[d]),
      .out_data   (f_data),
      .out_keep   (f_keep),
      .out_last   (f_last)
    );
  end

endmodule

// File: tb/tb_loopback_link_emu.sv
// Directed/random bench for loopback_link_emu: cross-mode instance a,
// self-loopback instance b, checked against a spec-level timing model.
module tb_loopback_link_emu;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  logic [NP*DW-1:0] a_s_tdata, a_m_tdata, b_s_tdata, b_m_tdata;
  logic [NP*KW-1:0] a_s_tkeep, a_m_tkeep, b_s_tkeep, b_m_tkeep;
  logic [NP-1:0]    a_s_tlast, a_s_tvalid, a_s_tready, a_m_tlast;
  logic [NP-1:0]    a_m_tvalid, a_m_tready, a_link_en, a_link_up;
  logic [NP-1:0]    b_s_tlast, b_s_tvalid, b_s_tready, b_m_tlast;
  logic [NP-1:0]    b_m_tvalid, b_m_tready, b_link_en, b_link_up;
  logic [NP*16-1:0] a_cfg_delay, a_frame_cnt, b_cfg_delay, b_frame_cnt;

  int          n_assert = 0;
  int          n_fail = 0;
  int          fc_model [NP];
  logic [15:0] now_m;

  always #5 CLK = ~CLK;

  // Spec counter: zero in reset, +1 per cycle, modulo 2^16.
  always @(posedge CLK) now_m <= RESET ? 16'd0 : now_m + 16'd1;

  loopback_link_emu #(.MODE(0)) u_a (
    .CLK(CLK), .RESET(RESET),
    .s_tdata(a_s_tdata), .s_tkeep(a_s_tkeep), .s_tlast(a_s_tlast),
    .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep), .m_tlast(a_m_tlast),
    .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
    .link_en(a_link_en), .cfg_delay(a_cfg_delay),
    .link_up(a_link_up), .frame_cnt(a_frame_cnt)
  );

  loopback_link_emu #(.MODE(1)) u_b (
    .CLK(CLK), .RESET(RESET),
    .s_tdata(b_s_tdata), .s_tkeep(b_s_tkeep), .s_tlast(b_s_tlast),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tlast(b_m_tlast),
    .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .link_en(b_link_en), .cfg_delay(b_cfg_delay),
    .link_up(b_link_up), .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input int p, input logic [DW-1:0] d,
                         input logic [KW-1:0] k, input logic l);
    a_s_tdata[p*DW +: DW] = d;
    a_s_tkeep[p*KW +: KW] = k;
    a_s_tlast[p]          = l;
    a_s_tvalid[p]         = 1'b1;
  endtask

  // One frame on instance a; beat j must egress max(dly,1)+j cycles
  // after the first acceptance. cfg_delay moves mid-frame and must not bite.
  task automatic send_frame(input int src, input int nb, input int dly);
    int dst, lat, got;
    logic [DW-1:0] qd[$];
    logic [KW-1:0] qk[$];
    dst = src ^ 1;
    lat = (dly > 1) ? dly : 1;
    a_cfg_delay[dst*16 +: 16] = 16'(dly);
    tick();
    for (int j = 0; j < nb; j++) begin
      qd.push_back({$urandom, $urandom});
      qk.push_back(8'($urandom_range(1, 255)));
    end
    got = 0;
    drive_a(src, qd[0], qk[0], nb == 1);
    for (int i = 0; i < lat + nb + 12; i++) begin
      @(negedge CLK);
      if (i < nb) chk("s_tready_accept", a_s_tready[src], 1'b1);
      if (a_m_tvalid[dst]) begin
        if (got < nb) begin
          chk("egress_cycle", i, lat + got);
          chk("egress_data", a_m_tdata[dst*DW +: DW], qd[got]);
          chk("egress_keep", a_m_tkeep[dst*KW +: KW], qk[got]);
          chk("egress_last", a_m_tlast[dst], got == nb - 1);
        end
        got++;
      end
      tick();
      if (i == 0) a_cfg_delay[dst*16 +: 16] = 16'(dly + 20);
      if (i + 1 < nb) drive_a(src, qd[i+1], qk[i+1], i + 1 == nb - 1);
      else a_s_tvalid[src] = 1'b0;
    end
    chk("beat_count", got, nb);
    if (fc_model[dst] < 65535) fc_model[dst]++;
    chk("frame_cnt", a_frame_cnt[dst*16 +: 16], fc_model[dst]);
  endtask

  initial begin
    int up_at, early, acc, got, fcb, stray, k;
    logic [DW-1:0] wd, first_d;
    logic          wl;
    logic [15:0]   first_now;
    logic [DW-1:0] bq[$];
    logic          bl[$];

    a_s_tdata = '0; a_s_tkeep = '0; a_s_tlast = '0; a_s_tvalid = '0;
    b_s_tdata = '0; b_s_tkeep = '1; b_s_tlast = '0; b_s_tvalid = '0;
    a_m_tready = '1; b_m_tready = '1;
    a_link_en = '0; b_link_en = '0;
    a_cfg_delay = '0; b_cfg_delay = '0;
    for (int p = 0; p < NP; p++) fc_model[p] = 0;

    repeat (3) tick();
    @(negedge CLK);
    chk("rst_link_up", a_link_up, 4'h0);
    chk("rst_s_tready", a_s_tready, 4'h0);
    chk("rst_m_tvalid", a_m_tvalid, 4'h0);
    chk("rst_m_tdata_nz", 64'(a_m_tdata != '0), 64'd0);
    chk("rst_frame_cnt", a_frame_cnt[63:0], 64'd0);

    // Training: TRAIN entered at the first edge after release.
    tick();
    RESET = 1'b0;
    a_link_en = '1;
    b_link_en = '1;
    up_at = -1;
    early = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (up_at < 0 && a_link_up == 4'hF) up_at = i;
      if (up_at < 0 && a_s_tready != 4'h0) early++;
    end
    chk("link_up_latency", up_at, 65);
    chk("tready_before_up", early, 0);
    chk("b_link_up", b_link_up, 4'hF);

    send_frame(1, 3, 10);
    send_frame(0, 1, 0);
    for (int r = 0; r < 3; r++) begin
      send_frame(3 - r, $urandom_range(1, 4), $urandom_range(0, 6));
    end

    // Self loopback fill to full, then push+pop in the same cycle.
    b_m_tready[2] = 1'b0;
    acc = 0;
    fcb = 0;
    wd = {$urandom, $urandom};
    wl = 1'($urandom);
    b_s_tdata[2*DW +: DW] = wd;
    b_s_tlast[2] = wl;
    b_s_tvalid[2] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (acc > 0 && b_m_tvalid[2]) chk("hold_stable", b_m_tdata[2*DW +: DW], bq[0]);
      if (b_s_tready[2]) begin
        bq.push_back(wd);
        bl.push_back(wl);
        fcb += int'(wl);
        acc++;
        tick();
        wd = {$urandom, $urandom};
        wl = 1'($urandom);
        b_s_tdata[2*DW +: DW] = wd;
        b_s_tlast[2] = wl;
      end else begin
        tick();
      end
    end
    chk("fill_count", acc, 16);
    chk("full_tready", b_s_tready[2], 1'b0);
    b_m_tready[2] = 1'b1;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (i == 0) chk("push_pop_full", b_s_tready[2], 1'b1);
      if (b_s_tvalid[2] && b_s_tready[2]) begin
        bq.push_back(wd);
        bl.push_back(wl);
        fcb += int'(wl);
      end
      if (b_m_tvalid[2]) begin
        if (bq.size() > 0) begin
          chk("drain_data", b_m_tdata[2*DW +: DW], bq.pop_front());
          chk("drain_last", b_m_tlast[2], bl.pop_front());
        end
        got++;
      end
      tick();
      b_s_tvalid[2] = 1'b0;
    end
    chk("drain_count", got, 17);
    chk("b_frame_cnt", b_frame_cnt[2*16 +: 16], fcb);

    // Counter wrap: accept at 16'hFFFC with delay 8.
    a_cfg_delay[0 +: 16] = 16'd8;
    k = 0;
    while (now_m != 16'hFFFC && k < 70000) begin
      tick();
      k++;
    end
    chk("wrap_reach", now_m, 16'hFFFC);
    first_d = {$urandom, $urandom};
    drive_a(1, first_d, 8'hFF, 1'b1);
    @(negedge CLK);
    chk("wrap_accept", a_s_tready[1], 1'b1);
    tick();
    a_s_tvalid[1] = 1'b0;
    first_now = 16'hDEAD;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (a_m_tvalid[0] && first_now == 16'hDEAD) begin
        first_now = now_m;
        chk("wrap_data", a_m_tdata[0 +: DW], first_d);
      end
      tick();
    end
    chk("wrap_eligible", first_now, 16'h0004);
    fc_model[0]++;
    chk("wrap_frame_cnt", a_frame_cnt[0 +: 16], fc_model[0]);

    // Link drop with 5 queued words for destination 1.
    a_m_tready[1] = 1'b0;
    a_cfg_delay[16 +: 16] = 16'd0;
    tick();
    for (int j = 0; j < 5; j++) begin
      drive_a(0, {$urandom, $urandom}, 8'hFF, 1'b0);
      @(negedge CLK);
      chk("drop_fill", a_s_tready[0], 1'b1);
      tick();
    end
    a_link_en[1] = 1'b0;
    @(negedge CLK);
    chk("drop_pre_valid", a_m_tvalid[1], 1'b1);
    tick();
    @(negedge CLK);
    chk("drop_m_tvalid", a_m_tvalid[1], 1'b0);
    chk("drop_link_up", a_link_up[1], 1'b0);
    chk("drop_s_tready", a_s_tready[0], 1'b0);
    chk("drop_frame_cnt", a_frame_cnt[16 +: 16], fc_model[1]);
    tick();
    a_s_tvalid[0] = 1'b0;
    a_link_en[1] = 1'b1;
    a_m_tready[1] = 1'b1;
    stray = 0;
    k = 0;
    while (!a_link_up[1] && k < 200) begin
      @(negedge CLK);
      if (a_m_tvalid[1]) stray++;
      tick();
      k++;
    end
    repeat (5) begin
      @(negedge CLK);
      if (a_m_tvalid[1]) stray++;
      tick();
    end
    chk("drop_retrain", a_link_up[1], 1'b1);
    chk("drop_flushed", stray, 0);

    // Reset mid-frame.
    a_cfg_delay[0 +: 16] = 16'd3;
    tick();
    for (int j = 0; j < 2; j++) begin
      drive_a(1, {$urandom, $urandom}, 8'hFF, 1'b0);
      tick();
    end
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk("mid_rst_s_tready", a_s_tready, 4'h0);
    chk("mid_rst_m_tvalid", a_m_tvalid, 4'h0);
    chk("mid_rst_m_tdata_nz", 64'(a_m_tdata != '0), 64'd0);
    chk("mid_rst_m_tkeep", a_m_tkeep, 32'h0);
    chk("mid_rst_m_tlast", a_m_tlast, 4'h0);
    chk("mid_rst_link_up", a_link_up, 4'h0);
    for (int p = 0; p < NP; p++) fc_model[p] = 0;
    chk("mid_rst_frame_cnt", a_frame_cnt[63:0], 64'd0);
    tick();
    RESET = 1'b0;
    a_s_tvalid = '0;
    stray = 0;
    k = 0;
    while (a_link_up != 4'hF && k < 200) begin
      @(negedge CLK);
      if (a_m_tvalid != 4'h0) stray++;
      tick();
      k++;
    end
    chk("post_rst_up", a_link_up, 4'hF);
    chk("post_rst_stale", stray, 0);
    send_frame(1, 4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
